// File: rtl/ovr_argmax_classifier.sv
// ovr_argmax_classifier
// Final stage after the per-class one-vs-all inner-product units. Takes one
// signed hidden score per beat, in class-index order, and tracks the running
// maximum. It then presents the winning class, its score, a positive flag
// (score >= 0, i.e. sigmoid >= 0.5) and a frame-length error flag on a
// valid/ready output.
//
//  state   | meaning
//  --------+-----------------------------------------------------------------
//  ST_ACC  | accepting score beats; in_ready=1; beat_cnt = beats taken so far
//  ST_OUT  | result held on outputs with out_valid=1 until out_ready
//
// A frame closes on the beat carrying in_last, or on the NUM_CLASSES-th beat,
// whichever comes first. Any disagreement between those two events flags
// out_error. If the frame closes on count alone, the next beat opens a new
// frame.

module ovr_argmax_classifier #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 32,
  parameter int IDX_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SCORE_W-1:0] in_score,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_class,
  output logic [SCORE_W-1:0] out_score,
  output logic               out_positive,
  output logic               out_error
);

  typedef enum logic [0:0] {
    ST_ACC = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_CLASSES - 1);

  state_t             state_q,      state_d;
  logic [IDX_W-1:0]   beat_cnt_q,   beat_cnt_d;
  logic [SCORE_W-1:0] max_score_q,  max_score_d;
  logic [IDX_W-1:0]   max_idx_q,    max_idx_d;
  logic               out_valid_q,  out_valid_d;
  logic [IDX_W-1:0]   out_class_q,  out_class_d;
  logic [SCORE_W-1:0] out_score_q,  out_score_d;
  logic               out_pos_q,    out_pos_d;
  logic               out_err_q,    out_err_d;

  logic               beat_acc;
  logic               first_beat;
  logic               count_full;
  logic               frame_end;
  logic               take_new;
  logic [SCORE_W-1:0] cand_score;
  logic [IDX_W-1:0]   cand_idx;

  // Beat-level decode: acceptance, frame close and the updated running max
  always_comb begin
    beat_acc   = in_valid && (state_q == ST_ACC);
    first_beat = (beat_cnt_q == '0);
    count_full = (beat_cnt_q == LAST_BEAT);
    frame_end  = beat_acc && (in_last || count_full);
    // Strict greater-than so that ties keep the earlier (lower) index
    take_new   = first_beat || ($signed(in_score) > $signed(max_score_q));
    cand_score = take_new ? in_score   : max_score_q;
    cand_idx   = take_new ? beat_cnt_q : max_idx_q;
  end

  // Next-state and next-output computation for the accept/present FSM
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    max_score_d = max_score_q;
    max_idx_d   = max_idx_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    out_score_d = out_score_q;
    out_pos_d   = out_pos_q;
    out_err_d   = out_err_q;

    case (state_q)
      ST_ACC: begin
        if (beat_acc) begin
          max_score_d = cand_score;
          max_idx_d   = cand_idx;
          if (frame_end) begin
            state_d     = ST_OUT;
            beat_cnt_d  = '0;
            out_valid_d = 1'b1;
            out_class_d = cand_idx;
            out_score_d = cand_score;
            out_pos_d   = ~cand_score[SCORE_W-1];
            // Clean only when in_last lands exactly on the final class
            out_err_d   = (in_last != count_full);
          end else begin
            beat_cnt_d = beat_cnt_q + IDX_W'(1);
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d     = ST_ACC;
          beat_cnt_d  = '0;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_ACC;
        beat_cnt_d  = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and result registers; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      beat_cnt_q  <= '0;
      max_score_q <= '0;
      max_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_score_q <= '0;
      out_pos_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      max_score_q <= max_score_d;
      max_idx_q   <= max_idx_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      out_score_q <= out_score_d;
      out_pos_q   <= out_pos_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready     = (state_q == ST_ACC);
  assign out_valid    = out_valid_q;
  assign out_class    = out_class_q;
  assign out_score    = out_score_q;
  assign out_positive = out_pos_q;
  assign out_error    = out_err_q;

endmodule

// File: tb/tb_ovr_argmax_classifier.sv
// Self-checking bench for ovr_argmax_classifier: directed frames plus
// randomized frames, checked against a simple argmax reference model.

module tb_ovr_argmax_classifier;

  localparam int N  = 10;
  localparam int W  = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_score;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_class;
  logic [W-1:0]  out_score;
  logic          out_positive;
  logic          out_error;

  int errors = 0;
  int checks = 0;

  logic signed [W-1:0] sc [N];

  ovr_argmax_classifier #(.NUM_CLASSES(N), .SCORE_W(W), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_score(in_score), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
    .out_score(out_score), .out_positive(out_positive), .out_error(out_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".out_valid"}, W'(out_valid), 0);
    chk({tag, ".out_class"}, W'(out_class), 0);
    chk({tag, ".out_score"}, out_score, 0);
    chk({tag, ".out_positive"}, W'(out_positive), 0);
    chk({tag, ".out_error"}, W'(out_error), 0);
    chk({tag, ".in_ready"}, W'(in_ready), 1);
  endtask

  // Drive n beats from sc[], compare against the reference argmax, then
  // optionally stall the consumer for 'hold' cycles with in_valid high and
  // complete the output handshake.
  task automatic run_frame(input string tag, input int n, input bit last,
                           input int hold, input bit do_hs);
    int exp_idx;
    logic signed [W-1:0] exp_sc;
    bit exp_err;
    exp_idx = 0;
    for (int i = 1; i < n; i++)
      if (sc[i] > sc[exp_idx]) exp_idx = i;
    exp_sc  = sc[exp_idx];
    exp_err = (last != (n == N));

    for (int i = 0; i < n; i++) begin
      chk({tag, ".in_ready_beat"}, W'(in_ready), 1);
      chk({tag, ".out_valid_early"}, W'(out_valid), 0);
      in_valid = 1'b1;
      in_score = sc[i];
      in_last  = last && (i == n - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;

    chk({tag, ".out_valid_latency"}, W'(out_valid), 1);
    chk({tag, ".out_class"}, W'(out_class), W'(exp_idx));
    chk({tag, ".out_score"}, out_score, exp_sc);
    chk({tag, ".out_positive"}, W'(out_positive), W'(exp_sc >= 0));
    chk({tag, ".out_error"}, W'(out_error), W'(exp_err));

    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_score = $urandom;
      tick();
      chk({tag, ".hold_in_ready"}, W'(in_ready), 0);
      chk({tag, ".hold_out_valid"}, W'(out_valid), 1);
      chk({tag, ".hold_out_class"}, W'(out_class), W'(exp_idx));
      chk({tag, ".hold_out_score"}, out_score, exp_sc);
    end

    if (do_hs) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk({tag, ".out_valid_drop"}, W'(out_valid), 0);
      chk({tag, ".in_ready_back"}, W'(in_ready), 1);
    end
  endtask

  initial begin
    int n;
    bit last;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_score  = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    // 1: mixed scores with a tie at the max, lower index wins
    sc = '{5, -3, 90, 90, 7, 0, 1, 2, 3, 89};
    run_frame("t1", N, 1'b1, 0, 1'b1);

    // 2: all negative, max at the final class
    for (int i = 0; i < N; i++) sc[i] = -100 + i;
    run_frame("t2", N, 1'b1, 0, 1'b1);

    // 3: signed extremes; an unsigned compare would pick index 0
    for (int i = 0; i < N; i++) sc[i] = i;
    sc[0] = 32'h8000_0000;
    sc[5] = 32'h7FFF_FFFF;
    run_frame("t3", N, 1'b1, 0, 1'b1);

    // max score exactly zero counts as positive
    for (int i = 0; i < N; i++) sc[i] = -7 - i;
    sc[6] = 0;
    run_frame("zero_max", N, 1'b1, 0, 1'b1);

    // 4: short frame, then a clean full frame
    sc[0] = 1; sc[1] = 2; sc[2] = 3; sc[3] = 4;
    run_frame("t4_short", 4, 1'b1, 0, 1'b1);
    for (int i = 0; i < N; i++) sc[i] = 3 * i - 11;
    run_frame("t4_clean", N, 1'b1, 0, 1'b1);

    // 10 beats without in_last: closed with error, next frame is fresh
    for (int i = 0; i < N; i++) sc[i] = 50 - i;
    run_frame("no_last", N, 1'b0, 0, 1'b1);
    for (int i = 0; i < N; i++) sc[i] = i * 2;
    run_frame("after_no_last", N, 1'b1, 0, 1'b1);

    // 5: consumer stall with in_valid high, then the next frame
    for (int i = 0; i < N; i++) sc[i] = 1000 - 37 * i;
    run_frame("t5_stall", N, 1'b1, 20, 1'b1);
    for (int i = 0; i < N; i++) sc[i] = (i == 0) ? 500 : 10 * i;
    run_frame("t5_next", N, 1'b1, 0, 1'b1);

    // 6a: reset after six beats of a frame
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_score = 200 + i;
      in_last  = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("t6_mid");
    for (int i = 0; i < N; i++) sc[i] = (i == 3) ? 77 : -i;
    run_frame("t6_mid_fresh", N, 1'b1, 0, 1'b1);

    // 6b: reset while the result is held in OUT
    for (int i = 0; i < N; i++) sc[i] = 40 + i;
    run_frame("t6_out_pre", N, 1'b1, 2, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_zero("t6_out");
    for (int i = 0; i < N; i++) sc[i] = (i == 8) ? 9 : i - 5;
    run_frame("t6_out_fresh", N, 1'b1, 0, 1'b1);

    // randomized frames: full range and narrow range (for ties)
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < N; i++)
        sc[i] = (f % 2 == 0) ? $urandom : (int'($urandom_range(0, 6)) - 3);
      case ($urandom_range(0, 3))
        0:       begin n = $urandom_range(1, N - 1); last = 1'b1; end
        1:       begin n = N; last = 1'b0; end
        default: begin n = N; last = 1'b1; end
      endcase
      run_frame("rand", n, last, $urandom_range(0, 3), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
